alu_seq: RTL and testbench



---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file read side, alu_seq and writeback.
// master = upstream/issue side, slave = the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [4:0]       flags;
  logic             flags_wr;
  logic [4:0]       flags_in;

  modport master (
    output in_valid, op, a, b, flags_wr, flags_in,
    input  in_ready, out_valid, result, err, flags
  );

  modport slave (
    input  in_valid, op, a, b, flags_wr, flags_in,
    output in_ready, out_valid, result, err, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a persistent {C,L,F,Z,N} flag register and iterative shifter.
// Single-cycle ops complete on the edge ending the accept cycle; shifts take one edge per bit.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int MSB = WIDTH - 1;
  localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDU = 4'd1,  OP_ADDC = 4'd2,  OP_SUB = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8,  OP_LSH  = 4'd9,  OP_ASH  = 4'd10, OP_MOV = 4'd11;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [MSB:0]     shv_reg, shv_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic             left_reg, left_next;
  logic             arith_reg, arith_next;
  logic [MSB:0]     result_reg, result_next;
  logic [4:0]       flags_reg, flags_next;
  logic             out_valid_reg, out_valid_next;
  logic             err_reg, err_next;

  logic             accept;
  logic [WIDTH:0]   add_sum, addc_sum, sub_diff;
  logic [SHW-1:0]   sh_amt, sh_mag, sh_len;
  logic             sh_neg;
  logic [MSB:0]     step_src;
  logic             step_left, step_arith;
  logic [WIDTH:0]   step;          // {bit shifted out, shifted value}
  logic             set_zn, clr_clf;

  assign accept   = bus.in_valid && (state_reg == IDLE);
  assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign addc_sum = add_sum + {{WIDTH{1'b0}}, flags_reg[FC]};
  assign sub_diff = {1'b0, bus.a} - {1'b0, bus.b};

  // Shift amount is a signed field; magnitude is clipped so a full-width shift empties the word.
  assign sh_amt = bus.b[SHW-1:0];
  assign sh_neg = sh_amt[SHW-1];
  assign sh_mag = sh_neg ? (~sh_amt + SHW'(1)) : sh_amt;
  assign sh_len = (sh_mag > SHW'(WIDTH)) ? SHW'(WIDTH) : sh_mag;

  // One shared one-bit shifter: first bit comes from operand A, later bits from the working register.
  always_comb begin
    step_src   = bus.a;
    step_left  = ~sh_neg;
    step_arith = (bus.op == OP_ASH);
    if (state_reg == SHIFT) begin
      step_src   = shv_reg;
      step_left  = left_reg;
      step_arith = arith_reg;
    end
    if (step_left) begin
      step = {step_src, 1'b0};
    end else begin
      step = {step_src[0], step_arith & step_src[MSB], step_src[MSB:1]};
    end
  end

  always_comb begin
    state_next     = state_reg;
    shv_next       = shv_reg;
    cnt_next       = cnt_reg;
    left_next      = left_reg;
    arith_next     = arith_reg;
    result_next    = result_reg;
    flags_next     = flags_reg;
    out_valid_next = 1'b0;
    err_next       = err_reg;
    set_zn         = 1'b0;
    clr_clf        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          out_valid_next = 1'b1;
          err_next       = 1'b0;
          set_zn         = 1'b1;
          case (bus.op)
            OP_ADD: begin
              result_next    = add_sum[MSB:0];
              flags_next[FF] = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
              flags_next[FL] = 1'b0;
            end
            OP_ADDU: begin
              result_next    = add_sum[MSB:0];
              flags_next[FC] = add_sum[WIDTH];
              flags_next[FL] = 1'b0;
            end
            OP_ADDC: begin
              result_next    = addc_sum[MSB:0];
              flags_next[FC] = addc_sum[WIDTH];
              flags_next[FF] = (bus.a[MSB] == bus.b[MSB]) && (addc_sum[MSB] != bus.a[MSB]);
              flags_next[FL] = 1'b0;
            end
            OP_SUB: begin
              result_next    = sub_diff[MSB:0];
              flags_next[FC] = sub_diff[WIDTH];
              flags_next[FF] = (bus.a[MSB] != bus.b[MSB]) && (sub_diff[MSB] != bus.a[MSB]);
              flags_next[FL] = 1'b0;
            end
            OP_CMP: begin
              set_zn         = 1'b0;
              result_next    = bus.a;
              flags_next[FC] = 1'b0;
              flags_next[FF] = 1'b0;
              flags_next[FL] = bus.a < bus.b;
              flags_next[FN] = $signed(bus.a) < $signed(bus.b);
              flags_next[FZ] = bus.a == bus.b;
            end
            OP_AND: begin result_next = bus.a & bus.b; clr_clf = 1'b1; end
            OP_OR:  begin result_next = bus.a | bus.b; clr_clf = 1'b1; end
            OP_XOR: begin result_next = bus.a ^ bus.b; clr_clf = 1'b1; end
            OP_NOT: begin result_next = ~bus.a;        clr_clf = 1'b1; end
            OP_LSH, OP_ASH: begin
              if (sh_len == '0) begin
                result_next = bus.a;
                clr_clf     = 1'b1;
              end else if (sh_len == SHW'(1)) begin
                result_next    = step[MSB:0];
                clr_clf        = 1'b1;
                flags_next[FC] = step[WIDTH];
              end else begin
                out_valid_next = 1'b0;
                set_zn         = 1'b0;
                state_next     = SHIFT;
                shv_next       = step[MSB:0];
                cnt_next       = sh_len - SHW'(1);
                left_next      = ~sh_neg;
                arith_next     = (bus.op == OP_ASH);
              end
            end
            OP_MOV: result_next = bus.b;
            default: begin
              set_zn      = 1'b0;
              result_next = '0;
              err_next    = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        shv_next = step[MSB:0];
        cnt_next = cnt_reg - SHW'(1);
        if (cnt_reg == SHW'(1)) begin
          state_next     = IDLE;
          out_valid_next = 1'b1;
          err_next       = 1'b0;
          result_next    = step[MSB:0];
          clr_clf        = 1'b1;
          flags_next[FC] = step[WIDTH];
          set_zn         = 1'b1;
        end
      end
    endcase

    if (clr_clf) begin
      flags_next[FL] = 1'b0;
      flags_next[FF] = 1'b0;
      if (!(state_reg == SHIFT || sh_len != '0) || !accept) begin
        flags_next[FC] = flags_next[FC];
      end
    end
    if (clr_clf && (state_reg == IDLE) && (bus.op != OP_LSH) && (bus.op != OP_ASH)) begin
      flags_next[FC] = 1'b0;
    end
    if (clr_clf && (state_reg == IDLE) && (sh_len == '0) && ((bus.op == OP_LSH) || (bus.op == OP_ASH))) begin
      flags_next[FC] = 1'b0;
    end
    if (set_zn) begin
      flags_next[FZ] = (result_next == '0);
      flags_next[FN] = result_next[MSB];
    end
    // A context restore overrides whatever the completing op computed.
    if (bus.flags_wr) begin
      flags_next = bus.flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shv_reg       <= '0;
      cnt_reg       <= '0;
      left_reg      <= 1'b0;
      arith_reg     <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shv_reg       <= shv_next;
      cnt_reg       <= cnt_next;
      left_reg      <= left_next;
      arith_reg     <= arith_next;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.err       = err_reg;
  assign bus.flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, held-request/busy behaviour,
// reset during a shift and randomized ops against a plain-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] fl_m = 5'd0;

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference: flags are {C,L,F,Z,N}; lat is the number of edges from accept to out_valid.
  function automatic void model(input int op, input int a, input int b, input logic [4:0] fl_in,
                                output int res, output logic [4:0] fl_out, output bit er, output int lat);
    int s, n, sa, ci;
    bit c, l, f, z, nn, zn;
    c = fl_in[4]; l = fl_in[3]; f = fl_in[2]; z = fl_in[1]; nn = fl_in[0];
    er = 1'b0; lat = 1; zn = 1'b1; res = 0;
    ci = c ? 1 : 0;
    case (op)
      0: begin s = a + b; res = s & 'hFFFF; f = (sgn(a) + sgn(b)) != sgn(res); l = 0; end
      1: begin s = a + b; res = s & 'hFFFF; c = s > 'hFFFF; l = 0; end
      2: begin s = a + b + ci; res = s & 'hFFFF; c = s > 'hFFFF; f = (sgn(a) + sgn(b) + ci) != sgn(res); l = 0; end
      3: begin res = (a - b) & 'hFFFF; c = a < b; f = (sgn(a) - sgn(b)) != sgn(res); l = 0; end
      4: begin res = a; l = a < b; nn = sgn(a) < sgn(b); z = a == b; c = 0; f = 0; zn = 0; end
      5: begin res = a & b; c = 0; l = 0; f = 0; end
      6: begin res = a | b; c = 0; l = 0; f = 0; end
      7: begin res = a ^ b; c = 0; l = 0; f = 0; end
      8: begin res = (~a) & 'hFFFF; c = 0; l = 0; f = 0; end
      9, 10: begin
        s = b & 31;
        if (s >= 16) s = s - 32;
        n = (s < 0) ? -s : s;
        if (n > W) n = W;
        if (n == 0) begin
          res = a; c = 0;
        end else if (s > 0) begin
          res = (a << n) & 'hFFFF; c = ((a >> (W - n)) & 1) != 0; lat = n;
        end else if (op == 9) begin
          res = a >> n; c = ((a >> (n - 1)) & 1) != 0; lat = n;
        end else begin
          sa = sgn(a); res = (sa >>> n) & 'hFFFF; c = ((sa >>> (n - 1)) & 1) != 0; lat = n;
        end
        l = 0; f = 0;
      end
      11: res = b;
      default: begin res = 0; er = 1'b1; zn = 1'b0; end
    endcase
    if (zn) begin z = (res == 0); nn = (res >= 32768); end
    fl_out = {c, l, f, z, nn};
  endfunction

  task automatic run_op(input int op, input int a, input int b, input bit fw, input logic [4:0] fin,
                        output int r_res, output logic [4:0] r_fl, output logic r_err,
                        output int r_lat, output int r_busy_hi);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op[3:0];
    bus.a = a[15:0];
    bus.b = b[15:0];
    bus.flags_wr = fw;
    bus.flags_in = fin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flags_wr = 1'b0;
    r_lat = 1;
    r_busy_hi = 0;
    while (bus.out_valid !== 1'b1 && r_lat < 40) begin
      if (bus.in_ready !== 1'b0) r_busy_hi++;
      @(posedge clk); #1;
      r_lat++;
    end
    r_res = int'(bus.result);
    r_fl = bus.flags;
    r_err = bus.err;
    $display("op=%0d a=%h b=%h fw=%0b fin=%b -> res=%h flags=%b err=%b cycles=%0d",
             op, a[15:0], b[15:0], fw, fin, bus.result, bus.flags, bus.err, r_lat);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    bus.flags_wr = 1'b0; bus.flags_in = 5'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b required 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL reset result: got %h required 0000", bus.result); end
    n_cmp++; if (bus.flags !== 5'h00) begin n_bad++; $display("FAIL reset flags: got %b required 00000", bus.flags); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b required 0", bus.err); end
    fl_m = 5'd0;
  endtask

  task automatic test_directed();
    int d_op [15] = '{1, 2, 0, 3, 4, 4, 9, 10, 13, 0, 2, 9, 10, 9, 11};
    int d_a  [15] = '{'hFFFF, 1, 'h7FFF, 0, 'hFFFF, 5, 'h8001, 'h8000, 'h1234, 'h1234, 1, 1, 'h1234, 1, 0};
    int d_b  [15] = '{1, 0, 1, 1, 1, 5, 3, 'h11, 'h5678, 1, 1, 'h1F, 0, 'h10, 'h8000};
    int d_fw [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int d_fin[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1F, 0, 0, 0, 0, 0};
    int d_res[15] = '{0, 2, 'h8000, 'hFFFF, 'hFFFF, 5, 8, 'hFFFF, 0, 'h1235, 3, 0, 'h1234, 0, 'h8000};
    int d_fl [15] = '{'h12, 0, 'h05, 'h11, 'h01, 'h02, 0, 'h01, 'h01, 'h1F, 0, 'h12, 0, 'h02, 'h01};
    int d_lat[15] = '{1, 1, 1, 1, 1, 1, 3, 15, 1, 1, 1, 1, 1, 16, 1};
    int d_err[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int r_res, r_lat, r_busy;
    logic [4:0] r_fl, fin;
    logic r_err;
    for (int i = 0; i < 15; i++) begin
      fin = d_fin[i][4:0];
      run_op(d_op[i], d_a[i], d_b[i], d_fw[i] != 0, fin, r_res, r_fl, r_err, r_lat, r_busy);
      n_cmp++; if (r_res !== d_res[i]) begin n_bad++; $display("FAIL dir%0d result: got %h required %h", i, r_res, d_res[i]); end
      n_cmp++; if (int'(r_fl) !== d_fl[i]) begin n_bad++; $display("FAIL dir%0d flags: got %b required %b", i, r_fl, d_fl[i][4:0]); end
      n_cmp++; if (r_lat !== d_lat[i]) begin n_bad++; $display("FAIL dir%0d latency: got %0d required %0d", i, r_lat, d_lat[i]); end
      n_cmp++; if (int'(r_err) !== d_err[i]) begin n_bad++; $display("FAIL dir%0d err: got %b required %0d", i, r_err, d_err[i]); end
      n_cmp++; if (r_busy !== 0) begin n_bad++; $display("FAIL dir%0d busy_in_ready: got %0d high cycles required 0", i, r_busy); end
      fl_m = d_fl[i][4:0];
    end
    // Output is a one-cycle pulse; result and flags hold afterwards.
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pulse out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 16'h8000) begin n_bad++; $display("FAIL hold result: got %h required 8000", bus.result); end
    // Context restore while idle.
    @(negedge clk);
    bus.flags_wr = 1'b1; bus.flags_in = 5'h0A;
    @(posedge clk); #1;
    bus.flags_wr = 1'b0;
    n_cmp++; if (bus.flags !== 5'h0A) begin n_bad++; $display("FAIL idle flags_wr: got %b required 01010", bus.flags); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle flags_wr out_valid: got %b required 0", bus.out_valid); end
    fl_m = 5'h0A;
  endtask

  task automatic test_hold_while_busy();
    int e1, e2, l1, l2, cyc;
    logic [4:0] f1, f2;
    bit er1, er2;
    model(9, 'h00F0, 4, fl_m, e1, f1, er1, l1);
    model(11, 0, 'hBEEF, f1, e2, f2, er2, l2);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd9; bus.a = 16'h00F0; bus.b = 16'h0004; bus.flags_wr = 1'b0;
    @(posedge clk); #1;
    bus.op = 4'd11; bus.a = 16'h0000; bus.b = 16'hBEEF;
    bus.flags_wr = 1'b1; bus.flags_in = 5'h15;
    cyc = 1;
    @(posedge clk); #1;
    cyc++;
    bus.flags_wr = 1'b0;
    n_cmp++; if (bus.flags !== 5'h15) begin n_bad++; $display("FAIL shift flags_wr: got %b required 10101", bus.flags); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL shift early out_valid: got %b required 0", bus.out_valid); end
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("hold LSH a=00f0 b=0004 -> res=%h flags=%b cycles=%0d", bus.result, bus.flags, cyc);
    n_cmp++; if (cyc !== l1) begin n_bad++; $display("FAIL hold latency: got %0d required %0d", cyc, l1); end
    n_cmp++; if (int'(bus.result) !== e1) begin n_bad++; $display("FAIL hold shift result: got %h required %h", bus.result, e1); end
    n_cmp++; if (bus.flags !== f1) begin n_bad++; $display("FAIL hold shift flags: got %b required %b", bus.flags, f1); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("hold MOV b=beef -> res=%h flags=%b out_valid=%b", bus.result, bus.flags, bus.out_valid);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL held mov out_valid: got %b required 1", bus.out_valid); end
    n_cmp++; if (int'(bus.result) !== e2) begin n_bad++; $display("FAIL held mov result: got %h required %h", bus.result, e2); end
    n_cmp++; if (bus.flags !== f2) begin n_bad++; $display("FAIL held mov flags: got %b required %b", bus.flags, f2); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL held mov pulse: got %b required 0", bus.out_valid); end
    fl_m = f2;
  endtask

  task automatic test_reset_mid_shift();
    int r_res, r_lat, r_busy, e_res, e_lat, ov_seen;
    logic [4:0] r_fl, e_fl;
    logic r_err;
    bit e_er;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd9; bus.a = 16'h1234; bus.b = 16'h0008;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-LSH -> res=%h flags=%b out_valid=%b in_ready=%b", bus.result, bus.flags, bus.out_valid, bus.in_ready);
    n_cmp++; if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL midreset result: got %h required 0000", bus.result); end
    n_cmp++; if (bus.flags !== 5'h00) begin n_bad++; $display("FAIL midreset flags: got %b required 00000", bus.flags); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset in_ready: got %b required 1", bus.in_ready); end
    ov_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) ov_seen++;
    end
    n_cmp++; if (ov_seen !== 0) begin n_bad++; $display("FAIL midreset out_valid: got %0d pulses required 0", ov_seen); end
    @(negedge clk);
    rst_n = 1'b1;
    fl_m = 5'd0;
    model(0, 'h1111, 'h2222, fl_m, e_res, e_fl, e_er, e_lat);
    run_op(0, 'h1111, 'h2222, 1'b0, 5'd0, r_res, r_fl, r_err, r_lat, r_busy);
    n_cmp++; if (r_res !== e_res) begin n_bad++; $display("FAIL post-reset add result: got %h required %h", r_res, e_res); end
    n_cmp++; if (r_fl !== e_fl) begin n_bad++; $display("FAIL post-reset add flags: got %b required %b", r_fl, e_fl); end
    n_cmp++; if (r_lat !== 1) begin n_bad++; $display("FAIL post-reset add latency: got %0d required 1", r_lat); end
    fl_m = e_fl;
  endtask

  task automatic test_random();
    int edge_vals[5] = '{0, 1, 'h7FFF, 'h8000, 'hFFFF};
    int op, a, b, e_res, e_lat, r_res, r_lat, r_busy;
    logic [4:0] e_fl, r_fl, fin;
    logic r_err;
    bit e_er, fw;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 15);
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom_range(0, 'hFFFF);
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom_range(0, 'hFFFF);
      fw = ($urandom_range(0, 7) == 0);
      fin = 5'($urandom_range(0, 31));
      model(op, a, b, fl_m, e_res, e_fl, e_er, e_lat);
      if (fw) begin
        if (e_lat == 1) e_fl = fin;
        else model(op, a, b, fin, e_res, e_fl, e_er, e_lat);
      end
      run_op(op, a, b, fw, fin, r_res, r_fl, r_err, r_lat, r_busy);
      n_cmp++; if (r_res !== e_res) begin n_bad++; $display("FAIL rnd%0d result op=%0d: got %h required %h", i, op, r_res, e_res); end
      n_cmp++; if (r_fl !== e_fl) begin n_bad++; $display("FAIL rnd%0d flags op=%0d: got %b required %b", i, op, r_fl, e_fl); end
      n_cmp++; if (r_err !== e_er) begin n_bad++; $display("FAIL rnd%0d err op=%0d: got %b required %b", i, op, r_err, e_er); end
      n_cmp++; if (r_lat !== e_lat) begin n_bad++; $display("FAIL rnd%0d latency op=%0d: got %0d required %0d", i, op, r_lat, e_lat); end
      n_cmp++; if (r_busy !== 0 || bus.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL rnd%0d in_ready: busy-high %0d, at completion %b required 0/1", i, r_busy, bus.in_ready);
      end
      fl_m = e_fl;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_while_busy();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
